// File: rtl/l2_pkg.sv
// Shared types and default widths for the L2 request arbiter.
package l2_pkg;

    localparam int unsigned L2_ADDR_W      = 32;
    localparam int unsigned L2_DATA_W      = 512;
    localparam int unsigned L2_OP_W        = 3;
    localparam int unsigned L2_ST_W        = 2;
    localparam int unsigned L2_TIMEOUT_CYC = 255;

    typedef enum logic [L2_OP_W-1:0] {
        OP_R      = 3'd0,
        OP_W      = 3'd1,
        OP_RWITM  = 3'd2,
        OP_FLUSH  = 3'd3,
        OP_UPDATE = 3'd4
    } l2_op_t;

    typedef enum logic [L2_ST_W-1:0] {
        ST_I = 2'd0,
        ST_S = 2'd1,
        ST_E = 2'd2,
        ST_M = 2'd3
    } l2_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_fsm_t;

    localparam logic REQ_IC = 1'b0;
    localparam logic REQ_DC = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not granted last.
module rr_arb2
    import l2_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       rr_last,
    output logic [1:0] grant_c
);

    always_comb begin
        grant_c = req_valid;
        if (req_valid == 2'b11) begin
            grant_c = (rr_last == REQ_DC) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/l2_req_arbiter.sv
// Shares the L2 request port between I-cache and D-cache with one transaction outstanding.
// Optional watchdog on the response wait: define L2ARB_TIMEOUT_EN.
module l2_req_arbiter
    import l2_pkg::*;
#(
    parameter int unsigned ADDR_W      = L2_ADDR_W,
    parameter int unsigned DATA_W      = L2_DATA_W,
    parameter int unsigned OP_W        = L2_OP_W,
    parameter int unsigned ST_W        = L2_ST_W,
    parameter int unsigned TIMEOUT_CYC = L2_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [OP_W-1:0]   ic_req_op,
    input  logic [ADDR_W-1:0] ic_req_addr,
    input  logic [DATA_W-1:0] ic_req_data,
    input  logic [ST_W-1:0]   ic_req_state,
    output logic              ic_resp_valid,
    output logic [DATA_W-1:0] ic_resp_data,
    output logic              ic_resp_err,
    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic [OP_W-1:0]   dc_req_op,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [DATA_W-1:0] dc_req_data,
    input  logic [ST_W-1:0]   dc_req_state,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] dc_resp_data,
    output logic              dc_resp_err,
    output logic              l2_req_valid,
    input  logic              l2_req_ready,
    output logic [OP_W-1:0]   l2_req_op,
    output logic [ADDR_W-1:0] l2_req_addr,
    output logic [DATA_W-1:0] l2_req_data,
    output logic [ST_W-1:0]   l2_req_state,
    input  logic              l2_resp_valid,
    input  logic [DATA_W-1:0] l2_resp_data,
    output logic              busy
);

    arb_fsm_t          state_q, state_d;
    logic              rr_last_q, rr_last_d;
    logic              owner_q, owner_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ST_W-1:0]   st_q, st_d;
    logic              l2_req_valid_q, l2_req_valid_d;
    logic              busy_q, busy_d;
    logic              ic_resp_valid_q, ic_resp_valid_d;
    logic              dc_resp_valid_q, dc_resp_valid_d;
    logic [DATA_W-1:0] ic_resp_data_q, ic_resp_data_d;
    logic [DATA_W-1:0] dc_resp_data_q, dc_resp_data_d;
    logic [1:0]        grant_c;
    logic              accept_c;

`ifdef L2ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ic_resp_err_q, ic_resp_err_d;
    logic              dc_resp_err_q, dc_resp_err_d;
`endif

    rr_arb2 u_rr_arb2 (
        .req_valid ({dc_req_valid, ic_req_valid}),
        .rr_last   (rr_last_q),
        .grant_c   (grant_c)
    );

    // Ready is offered only from IDLE and never while reset is asserted.
    assign ic_req_ready = rst & (state_q == IDLE) & grant_c[REQ_IC];
    assign dc_req_ready = rst & (state_q == IDLE) & grant_c[REQ_DC];
    assign accept_c     = ic_req_ready | dc_req_ready;

    always_comb begin
        state_d         = state_q;
        rr_last_d       = rr_last_q;
        owner_d         = owner_q;
        op_d            = op_q;
        addr_d          = addr_q;
        data_d          = data_q;
        st_d            = st_q;
        ic_resp_valid_d = 1'b0;
        dc_resp_valid_d = 1'b0;
        ic_resp_data_d  = ic_resp_data_q;
        dc_resp_data_d  = dc_resp_data_q;
`ifdef L2ARB_TIMEOUT_EN
        cnt_d           = cnt_q;
        ic_resp_err_d   = 1'b0;
        dc_resp_err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    owner_d   = grant_c[REQ_DC] ? REQ_DC : REQ_IC;
                    rr_last_d = owner_d;
                    op_d      = grant_c[REQ_DC] ? dc_req_op    : ic_req_op;
                    addr_d    = grant_c[REQ_DC] ? dc_req_addr  : ic_req_addr;
                    data_d    = grant_c[REQ_DC] ? dc_req_data  : ic_req_data;
                    st_d      = grant_c[REQ_DC] ? dc_req_state : ic_req_state;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (l2_req_ready) begin
                    state_d = WAIT;
`ifdef L2ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                if (l2_resp_valid) begin
                    state_d = IDLE;
                    if (owner_q == REQ_DC) begin
                        dc_resp_valid_d = 1'b1;
                        dc_resp_data_d  = l2_resp_data;
                    end else begin
                        ic_resp_valid_d = 1'b1;
                        ic_resp_data_d  = l2_resp_data;
                    end
                end
`ifdef L2ARB_TIMEOUT_EN
                // Watchdog: answer the owner with an error once the wait budget is used up.
                else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT_CYC)) begin
                        state_d = IDLE;
                        if (owner_q == REQ_DC) begin
                            dc_resp_valid_d = 1'b1;
                            dc_resp_err_d   = 1'b1;
                            dc_resp_data_d  = '0;
                        end else begin
                            ic_resp_valid_d = 1'b1;
                            ic_resp_err_d   = 1'b1;
                            ic_resp_data_d  = '0;
                        end
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        l2_req_valid_d = (state_d == ISSUE);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            rr_last_q       <= REQ_DC;
            owner_q         <= REQ_IC;
            op_q            <= '0;
            addr_q          <= '0;
            data_q          <= '0;
            st_q            <= '0;
            l2_req_valid_q  <= 1'b0;
            busy_q          <= 1'b0;
            ic_resp_valid_q <= 1'b0;
            dc_resp_valid_q <= 1'b0;
            ic_resp_data_q  <= '0;
            dc_resp_data_q  <= '0;
`ifdef L2ARB_TIMEOUT_EN
            cnt_q           <= '0;
            ic_resp_err_q   <= 1'b0;
            dc_resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            rr_last_q       <= rr_last_d;
            owner_q         <= owner_d;
            op_q            <= op_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            st_q            <= st_d;
            l2_req_valid_q  <= l2_req_valid_d;
            busy_q          <= busy_d;
            ic_resp_valid_q <= ic_resp_valid_d;
            dc_resp_valid_q <= dc_resp_valid_d;
            ic_resp_data_q  <= ic_resp_data_d;
            dc_resp_data_q  <= dc_resp_data_d;
`ifdef L2ARB_TIMEOUT_EN
            cnt_q           <= cnt_d;
            ic_resp_err_q   <= ic_resp_err_d;
            dc_resp_err_q   <= dc_resp_err_d;
`endif
        end
    end

    assign l2_req_valid  = l2_req_valid_q;
    assign l2_req_op     = op_q;
    assign l2_req_addr   = addr_q;
    assign l2_req_data   = data_q;
    assign l2_req_state  = st_q;
    assign busy          = busy_q;
    assign ic_resp_valid = ic_resp_valid_q;
    assign dc_resp_valid = dc_resp_valid_q;
    assign ic_resp_data  = ic_resp_data_q;
    assign dc_resp_data  = dc_resp_data_q;
`ifdef L2ARB_TIMEOUT_EN
    assign ic_resp_err   = ic_resp_err_q;
    assign dc_resp_err   = dc_resp_err_q;
`else
    assign ic_resp_err   = 1'b0;
    assign dc_resp_err   = 1'b0;
`endif

endmodule
